rl_fifo_1r1w: RTL and testbench
===============================

RL_FIFO_1R1W -- requirements
Module: rl_fifo_1r1w

Interface
REQ-001 SHALL have parameter ABITS, default 4, RAM address bits; RAM depth is 2**ABITS.
REQ-002 SHALL have parameter DBITS, default 32, data width in bits.
REQ-003 SHALL have parameter AF_LEVEL, default 2**ABITS, almost-full threshold compared against count_o.
REQ-004 SHALL have port clk_i, input, 1 bit, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit, reset, asynchronous, active-low.
REQ-006 SHALL have port clr_i, input, 1, synchronous flush.
REQ-007 SHALL have ports d_i (in, DBITS), valid_i (in, 1) and ready_o (out, 1) forming the push handshake.
REQ-008 SHALL have ports q_o (out, DBITS), valid_o (out, 1) and ready_i (in, 1) forming the pop handshake.
REQ-009 SHALL have RAM write ports ram_waddr_o (out, ABITS), ram_din_o (out, DBITS), ram_we_o (out, 1) and ram_be_o (out, (DBITS+7)/8).
REQ-010 SHALL have RAM read ports ram_raddr_o (out, ABITS), ram_re_o (out, 1) and ram_dout_i (in, DBITS); ram_dout_i is valid exactly one cycle after ram_re_o.
REQ-011 SHALL have status outputs count_o (ABITS+2 bits), empty_o (1), full_o (1) and almost_full_o (1).

Function
REQ-012 SHALL have total capacity 2**ABITS+2 entries: the RAM plus a 2-entry output buffer.
REQ-013 SHALL accept a push when valid_i&&ready_o; ready_o = !full_o, registered, with no combinational path from ready_i or valid_i.
REQ-014 SHALL drive, on an accepted push, ram_we_o=1, ram_waddr_o=wptr, ram_din_o=d_i and ram_be_o all-ones, with wptr incrementing modulo 2**ABITS.
REQ-015 SHALL issue a read, ram_re_o=1 and ram_raddr_o=rptr, when ram_cnt>0 and (buffered entries + in-flight reads) < 2; rptr increments modulo 2**ABITS.
REQ-016 SHALL update ram_cnt so that an accepted push increments it at the clock edge, allowing a read of that entry no earlier than the next cycle (no same-address read/write).
REQ-017 SHALL capture ram_dout_i into the output buffer on the cycle after ram_re_o, preserving order.
REQ-018 SHALL drive q_o from the oldest buffer entry and valid_o = (buffer non-empty); a pop occurs on valid_o&&ready_i.
REQ-019 SHALL sustain one push and one pop per cycle in steady state.
REQ-020 SHALL have 3-cycle push-to-valid_o latency into an empty FIFO: push in cycle t, read in t+1, capture in t+2, valid_o in t+3.
REQ-021 SHALL make count_o = RAM entries + in-flight reads + buffered entries, with empty_o=(count_o==0), full_o=(count_o==2**ABITS+2) and almost_full_o=(count_o>=AF_LEVEL).
REQ-022 SHALL leave count_o unchanged on a simultaneous push and pop.
REQ-023 SHALL ignore valid_i while full and ignore ready_i while empty; no state changes in either case.
REQ-024 SHALL on clr_i zero pointers, counts and buffer, discard in-flight read data, and force ram_we_o/ram_re_o to 0 in that cycle; clr_i overrides a same-cycle push or pop.

Reset
REQ-025 SHALL, while rst_ni=0, asynchronously force: wptr=rptr=0, count_o=0, empty_o=1, full_o=0, almost_full_o=0, ready_o=1, valid_o=0, q_o=0, ram_we_o=0, ram_re_o=0.
REQ-026 SHALL discard in-flight reads on reset assertion mid-operation and resume normal operation on the first edge after deassertion.

Configuration
REQ-027 SHALL, when RL_FIFO_1R1W_BYPASS_EN is defined, write a push straight into the output buffer (no RAM write) if ram_cnt==0, there are no in-flight reads and buffer space exists, giving 1-cycle push-to-valid_o latency; without the macro all data passes through RAM per REQ-020.

Verification
REQ-028 SHALL cover single push into empty FIFO (ABITS=2, DBITS=8): push 0xA5 in cycle 0 -> valid_o=1, q_o=0xA5 in cycle 3 (cycle 1 with bypass), count_o=1 meanwhile.
REQ-029 SHALL cover fill with ready_i=0: push 0x01..0x06 -> full_o=1, ready_o=0 after 6th; 7th push 0x07 ignored; pops return 0x01..0x06 in order.
REQ-030 SHALL cover streaming: continuous push of 0x00..0x1F with ready_i=1 -> one pop per cycle once primed, order kept, with pointers wrapping 3->0 without loss.
REQ-031 SHALL cover simultaneous push/pop when count_o=3 -> count_o stays 3, and pop on empty -> no change.
REQ-032 SHALL cover clr_i with 4 entries and a read in flight -> next cycle count_o=0, valid_o=0, and the late ram_dout_i is not captured.
REQ-033 SHALL cover rst_ni low mid-stream -> all outputs at reset values immediately, and after release a push of 0x3C pops as 0x3C.

Source files
------------

// File: rtl/rl_fifo_1r1w.sv
// ============================================================================
// Module   : rl_fifo_1r1w
// Brief    : Single-clock FIFO using an external 1R1W RAM with 1-cycle read
//            latency, plus a 2-entry output buffer. Optional push bypass
//            into the output buffer is enabled by RL_FIFO_1R1W_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rl_fifo_1r1w #(
    parameter int ABITS    = 4,
    parameter int DBITS    = 32,
    parameter int AF_LEVEL = 2**ABITS
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic [DBITS-1:0]     d_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DBITS-1:0]     q_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [ABITS-1:0]     ram_waddr_o,
    output logic [DBITS-1:0]     ram_din_o,
    output logic                 ram_we_o,
    output logic [(DBITS+7)/8-1:0] ram_be_o,
    output logic [ABITS-1:0]     ram_raddr_o,
    output logic                 ram_re_o,
    input  logic [DBITS-1:0]     ram_dout_i,
    output logic [ABITS+1:0]     count_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 almost_full_o
);

    localparam int               c_BEW = (DBITS+7)/8;
    localparam logic [ABITS+1:0] c_CAP = (ABITS+2)'(2**ABITS + 2);
    localparam logic [ABITS+1:0] c_AF  = (ABITS+2)'(AF_LEVEL);

    logic [ABITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ABITS:0]   ram_cnt_q, ram_cnt_d;
    logic [ABITS+1:0] count_q, count_d;
    logic             infl_q, infl_d;
    logic [1:0]       buf_cnt_q, buf_cnt_d;
    logic [DBITS-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

    logic             w_full, w_push, w_pop, w_byp, w_wr, w_rd, w_in_v;
    logic [2:0]       w_pend;
    logic [DBITS-1:0] w_in;

    assign w_full = (count_q == c_CAP);
    assign w_push = rst_ni && valid_i && !w_full;
    assign w_pop  = ready_i && (buf_cnt_q != 2'd0);

    // Slots the buffer will still owe after this cycle's pop; a read is only
    // issued if its data is guaranteed a free slot on arrival.
    assign w_pend = {1'b0, buf_cnt_q} + {2'b00, infl_q} - {2'b00, w_pop};
    assign w_rd   = !clr_i && (ram_cnt_q != '0) && (w_pend < 3'd2);

`ifdef RL_FIFO_1R1W_BYPASS_EN
    assign w_byp  = w_push && (ram_cnt_q == '0) && !infl_q
                    && (({1'b0, buf_cnt_q} - {2'b00, w_pop}) < 3'd2);
`else
    assign w_byp  = 1'b0;
`endif

    assign w_wr   = w_push && !w_byp && !clr_i;
    assign w_in_v = infl_q || w_byp;
    assign w_in   = infl_q ? ram_dout_i : d_i;

    always_comb begin
        wptr_d    = wptr_q + ABITS'(w_wr);
        rptr_d    = rptr_q + ABITS'(w_rd);
        ram_cnt_d = ram_cnt_q + (ABITS+1)'(w_wr) - (ABITS+1)'(w_rd);
        count_d   = count_q + (ABITS+2)'(w_push) - (ABITS+2)'(w_pop);
        infl_d    = w_rd;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        buf_cnt_d = buf_cnt_q;
        if (w_pop) begin
            buf0_d    = buf1_q;
            buf_cnt_d = buf_cnt_d - 2'd1;
        end
        if (w_in_v) begin
            if (buf_cnt_d == 2'd0) buf0_d = w_in;
            else                   buf1_d = w_in;
            buf_cnt_d = buf_cnt_d + 2'd1;
        end
        if (clr_i) begin
            wptr_d    = '0;
            rptr_d    = '0;
            ram_cnt_d = '0;
            count_d   = '0;
            infl_d    = 1'b0;
            buf0_d    = '0;
            buf1_d    = '0;
            buf_cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
            count_q   <= '0;
            infl_q    <= 1'b0;
            buf0_q    <= '0;
            buf1_q    <= '0;
            buf_cnt_q <= 2'd0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            count_q   <= count_d;
            infl_q    <= infl_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            buf_cnt_q <= buf_cnt_d;
        end
    end

    assign ready_o       = !w_full;
    assign q_o           = buf0_q;
    assign valid_o       = (buf_cnt_q != 2'd0);
    assign ram_waddr_o   = wptr_q;
    assign ram_din_o     = d_i;
    assign ram_we_o      = w_wr;
    assign ram_be_o      = {c_BEW{1'b1}};
    assign ram_raddr_o   = rptr_q;
    assign ram_re_o      = w_rd;
    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign full_o        = w_full;
    assign almost_full_o = (count_q >= c_AF);

endmodule

`default_nettype wire

// File: tb/tb_rl_fifo_1r1w.sv
// ============================================================================
// Module   : tb_rl_fifo_1r1w
// Brief    : Self-checking bench for rl_fifo_1r1w with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rl_fifo_1r1w;

    localparam int AB  = 2;
    localparam int DB  = 8;
    localparam int CAP = 6;
    localparam int AF  = 4;

    logic          clk = 1'b0, rst_n = 1'b0, clr = 1'b0, v = 1'b0, r = 1'b0;
    logic [DB-1:0] d = '0;
    logic          ready_o, valid_o, ram_we, ram_re, empty_o, full_o, af_o;
    logic [DB-1:0] q_o, ram_din, ram_dout;
    logic [AB-1:0] ram_waddr, ram_raddr;
    logic [0:0]    ram_be;
    logic [AB+1:0] count_o;

    int n_chk = 0;
    int n_err = 0;

    rl_fifo_1r1w #(.ABITS(AB), .DBITS(DB)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .d_i(d), .valid_i(v), .ready_o(ready_o),
        .q_o(q_o), .valid_o(valid_o), .ready_i(r),
        .ram_waddr_o(ram_waddr), .ram_din_o(ram_din), .ram_we_o(ram_we),
        .ram_be_o(ram_be), .ram_raddr_o(ram_raddr), .ram_re_o(ram_re),
        .ram_dout_i(ram_dout), .count_o(count_o), .empty_o(empty_o),
        .full_o(full_o), .almost_full_o(af_o)
    );

    always #5 clk = ~clk;

    // External RAM seen by the DUT: one-cycle registered read.
    logic [DB-1:0] mem [4];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_raddr];
    end

    // Reference model: contents of RAM, the one read in transit, the buffer.
    logic [DB-1:0] mram[$];
    logic [DB-1:0] mbuf[$];
    bit            minfl = 0;
    logic [DB-1:0] minfd = '0;
    int            mwp = 0, mrp = 0;

    function automatic int m_cnt();
        return mram.size() + int'(minfl) + mbuf.size();
    endfunction
    function automatic bit m_push();
        return rst_n && v && (m_cnt() < CAP);
    endfunction
    function automatic bit m_pop();
        return r && (mbuf.size() > 0);
    endfunction
    function automatic bit m_byp();
`ifdef RL_FIFO_1R1W_BYPASS_EN
        return m_push() && (mram.size() == 0) && !minfl
               && (mbuf.size() - int'(m_pop()) < 2);
`else
        return 1'b0;
`endif
    endfunction
    function automatic bit m_re();
        return rst_n && !clr && (mram.size() > 0)
               && (mbuf.size() + int'(minfl) - int'(m_pop()) < 2);
    endfunction
    function automatic bit m_we();
        return !clr && m_push() && !m_byp();
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            mram.delete(); mbuf.delete();
            minfl = 0; mwp = 0; mrp = 0;
        end else begin
            bit p, po, b, re;
            p = m_push(); po = m_pop(); b = m_byp(); re = m_re();
            if (po) void'(mbuf.pop_front());
            if (minfl) mbuf.push_back(minfd);
            if (b) mbuf.push_back(d);
            minfl = re;
            if (re) begin
                minfd = mram.pop_front();
                mrp = (mrp + 1) % 4;
            end
            if (p && !b) begin
                mram.push_back(d);
                mwp = (mwp + 1) % 4;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int c;
        c = m_cnt();
        chk("count", 32'(count_o), 32'(c));
        chk("empty", 32'(empty_o), 32'(c == 0));
        chk("full", 32'(full_o), 32'(c == CAP));
        chk("almost_full", 32'(af_o), 32'(c >= AF));
        chk("ready", 32'(ready_o), 32'(c != CAP));
        chk("valid", 32'(valid_o), 32'(mbuf.size() > 0));
        if (mbuf.size() > 0) chk("q", 32'(q_o), 32'(mbuf[0]));
        chk("ram_we", 32'(ram_we), 32'(m_we()));
        if (m_we()) begin
            chk("ram_waddr", 32'(ram_waddr), 32'(mwp));
            chk("ram_din", 32'(ram_din), 32'(d));
            chk("ram_be", 32'(ram_be), 32'd1);
        end
        chk("ram_re", 32'(ram_re), 32'(m_re()));
        if (m_re()) chk("ram_raddr", 32'(ram_raddr), 32'(mrp));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm, input int maxc);
        int k;
        k = 0;
        while (!valid_o && k < maxc) begin
            tick();
            k++;
        end
        if (!valid_o) chk({nm, "_timeout"}, 32'(valid_o), 32'd1);
    endtask

    initial begin
        int lat, exp, gaps, sent;
        bit started, acc;
`ifdef RL_FIFO_1R1W_BYPASS_EN
        lat = 1;
`else
        lat = 3;
`endif
        repeat (3) tick();
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single push into empty FIFO
        v = 1; d = 8'hA5;
        tick();
        v = 0;
        for (int c = 1; c <= 3; c++) begin
            chk("single_count", 32'(count_o), 32'd1);
            chk("single_valid", 32'(valid_o), 32'(c >= lat));
            if (c == lat) chk("single_q", 32'(q_o), 32'hA5);
            if (c < 3) tick();
        end
        r = 1; tick(); r = 0;
        chk("single_empty", 32'(empty_o), 32'd1);

        // Fill with ready_i low
        for (int i = 1; i <= 6; i++) begin
            v = 1; d = 8'(i); tick();
        end
        v = 0;
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_ready", 32'(ready_o), 32'd0);
        v = 1; d = 8'h07; tick(); v = 0;
        chk("fill_ignored", 32'(count_o), 32'd6);
        r = 1;
        for (int k = 1; k <= 6; k++) begin
            wait_valid("fill_pop", 8);
            chk("fill_order", 32'(q_o), 32'(k));
            tick();
        end
        r = 0;
        repeat (2) tick();
        chk("fill_drained", 32'(empty_o), 32'd1);

        // Streaming 0x00..0x1F with pointer wrap
        r = 1; exp = 0; gaps = 0; sent = 0; started = 0;
        for (int c = 0; c < 80; c++) begin
            v = (sent < 32); d = 8'(sent);
            acc = v && ready_o;
            if (valid_o) begin
                chk("stream_q", 32'(q_o), 32'(exp));
                exp++; started = 1;
            end else if (started && exp < 32) begin
                gaps++;
            end
            tick();
            if (acc) sent++;
        end
        v = 0; r = 0;
        chk("stream_total", 32'(exp), 32'd32);
        chk("stream_gaps", 32'(gaps), 32'd0);

        // Simultaneous push/pop at count 3, then pop on empty
        for (int i = 0; i < 3; i++) begin
            v = 1; d = 8'(8'h40 + i); tick();
        end
        v = 0;
        repeat (4) tick();
        chk("pp_pre", 32'(count_o), 32'd3);
        v = 1; d = 8'h55; r = 1; tick(); v = 0; r = 0;
        chk("pp_count", 32'(count_o), 32'd3);
        r = 1; repeat (10) tick();
        chk("pe_pre", 32'(count_o), 32'd0);
        tick();
        chk("pe_count", 32'(count_o), 32'd0);
        chk("pe_valid", 32'(valid_o), 32'd0);
        r = 0;

        // Clear with 4 entries and a read in flight
        for (int i = 0; i < 5; i++) begin
            v = 1; d = 8'(8'h80 + i); tick();
        end
        v = 0;
        repeat (5) tick();
        r = 1; #1;
        chk("clr_setup_re", 32'(ram_re), 32'd1);
        tick(); r = 0;
        chk("clr_setup_cnt", 32'(count_o), 32'd4);
        clr = 1; v = 1; d = 8'h99; #1;
        chk("clr_we", 32'(ram_we), 32'd0);
        chk("clr_re", 32'(ram_re), 32'd0);
        tick(); clr = 0; v = 0;
        chk("clr_count", 32'(count_o), 32'd0);
        chk("clr_valid", 32'(valid_o), 32'd0);
        repeat (3) tick();
        chk("clr_late", 32'(valid_o), 32'd0);

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 1500; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 2) != 0);
            d   = 8'($urandom);
            clr = ($urandom_range(0, 63) == 0);
            tick();
        end
        clr = 0; v = 0; r = 0;

        // Reset mid-stream
        v = 1; r = 1;
        for (int i = 0; i < 6; i++) begin
            d = 8'(8'hC0 + i); tick();
        end
        #2 rst_n = 0; #1;
        chk("arst_count", 32'(count_o), 32'd0);
        chk("arst_empty", 32'(empty_o), 32'd1);
        chk("arst_full", 32'(full_o), 32'd0);
        chk("arst_af", 32'(af_o), 32'd0);
        chk("arst_ready", 32'(ready_o), 32'd1);
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_q", 32'(q_o), 32'd0);
        chk("arst_we", 32'(ram_we), 32'd0);
        chk("arst_re", 32'(ram_re), 32'd0);
        v = 0; r = 0;
        repeat (2) tick();
        rst_n = 1;
        v = 1; d = 8'h3C; tick(); v = 0;
        wait_valid("post_rst", 6);
        chk("post_rst_q", 32'(q_o), 32'h3C);
        r = 1; tick(); r = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
